huc6280_core_lite: RTL and testbench

- Reduced HuC6280 (65C02-derived) CPU core with the HuC6280 8-bank MMU.
- Fetches and executes a fixed instruction subset from a synchronous byte-wide memory.
- Maps the 16-bit logical address (AB) to the 21-bit physical bus (AB_21).
- Top-level processor block of the test SoC; paired with a single-port 2 MB byte memory.

---
 rtl/huc6280_core_lite.sv | 265 ++++++++++++++++++++++++++
 tb/tb_huc6280_core_lite.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huc6280_core_lite.sv
// Reduced HuC6280 core: 65C02-style subset with the 8-bank MPR mapper.
// Bus: every read is an address cycle (RE=1) then a data cycle; writes take one WE cycle.
module huc6280_core_lite #(
    parameter logic [15:0] RESET_VEC = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    output logic [20:0] AB_21,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    output logic        RE,
    output logic        WE,
    input  logic        IRQ,
    input  logic        NMI,
    input  logic        RDY,
    output logic [2:0]  dbg_state_o,
    output logic [15:0] dbg_ab_o,
    output logic [15:0] dbg_pc_o,
    output logic [7:0]  dbg_a_o,
    output logic [7:0]  dbg_x_o,
    output logic [7:0]  dbg_y_o,
    output logic [7:0]  dbg_s_o,
    output logic [2:0]  dbg_nzc_o
);

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, OP1, OP2, MEMRD, MEMWR, EXEC
    } state_t;

    // Each read state walks issue -> address (RE=1) -> data (DI valid).
    localparam logic [1:0] PH_ISSUE = 2'd0;
    localparam logic [1:0] PH_ADDR  = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [15:0] ab_q, ab_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [7:0]  do_q, do_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, s_q, s_d;
    logic        n_q, n_d, z_q, z_d, c_q, c_d;
    logic [7:0]  ir_q, ir_d, op1_q, op1_d, op2_q, op2_d;
    logic [7:0]  mpr_q [8];
    logic [7:0]  mpr_d [8];

    logic [15:0] rd_addr;
    logic [7:0]  store_data;
    logic [7:0]  res;
    logic        set_nz;
    logic [8:0]  sum9;
    logic        unused_pins;

    assign unused_pins = IRQ ^ NMI;

    function automatic logic is_imm(input logic [7:0] op);
        return op inside {8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h53, 8'h43, 8'hD0, 8'hF0};
    endfunction

    function automatic logic is_abs(input logic [7:0] op);
        return op inside {8'hAD, 8'h8D, 8'h8E, 8'h8C, 8'h4C};
    endfunction

    // State register: everything freezes while RDY is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= VEC_LO;
            ph_q    <= PH_ISSUE;
            ab_q    <= 16'h0000;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            do_q    <= 8'h00;
            pc_q    <= 16'h0000;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            s_q     <= 8'hFF;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ir_q    <= 8'h00;
            op1_q   <= 8'h00;
            op2_q   <= 8'h00;
            for (int i = 0; i < 8; i++) mpr_q[i] <= 8'h00;
        end else if (RDY) begin
            state_q <= state_d;
            ph_q    <= ph_d;
            ab_q    <= ab_d;
            re_q    <= re_d;
            we_q    <= we_d;
            do_q    <= do_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            ir_q    <= ir_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            for (int i = 0; i < 8; i++) mpr_q[i] <= mpr_d[i];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        case (state_q)
            EXEC: begin
                state_d = FETCH;
                ph_d    = PH_ISSUE;
            end
            MEMWR: begin
                if (ph_q == PH_ISSUE) begin
                    ph_d = PH_ADDR;
                end else begin
                    state_d = FETCH;
                    ph_d    = PH_ISSUE;
                end
            end
            default: begin
                if (ph_q == PH_ISSUE) begin
                    ph_d = PH_ADDR;
                end else if (ph_q == PH_ADDR) begin
                    ph_d = PH_DATA;
                end else begin
                    ph_d = PH_ISSUE;
                    case (state_q)
                        VEC_LO:  state_d = VEC_HI;
                        VEC_HI:  state_d = FETCH;
                        FETCH:   state_d = (is_imm(DI) || is_abs(DI)) ? OP1 : EXEC;
                        OP1:     state_d = is_abs(ir_q) ? OP2 : EXEC;
                        OP2:     state_d = (ir_q == 8'hAD) ? MEMRD :
                                           (ir_q == 8'h4C) ? EXEC : MEMWR;
                        MEMRD:   state_d = EXEC;
                        default: state_d = FETCH;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        case (state_q)
            VEC_LO:  rd_addr = RESET_VEC;
            VEC_HI:  rd_addr = RESET_VEC + 16'd1;
            MEMRD:   rd_addr = {op2_q, op1_q};
            default: rd_addr = pc_q;
        endcase
        case (ir_q)
            8'h8E:   store_data = x_q;
            8'h8C:   store_data = y_q;
            default: store_data = a_q;
        endcase
    end

    // Bus outputs and datapath updates.
    always_comb begin
        ab_d   = ab_q;
        re_d   = 1'b0;
        we_d   = 1'b0;
        do_d   = do_q;
        pc_d   = pc_q;
        a_d    = a_q;
        x_d    = x_q;
        y_d    = y_q;
        s_d    = s_q;
        n_d    = n_q;
        z_d    = z_q;
        c_d    = c_q;
        ir_d   = ir_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        mpr_d  = mpr_q;
        res    = 8'h00;
        set_nz = 1'b0;
        sum9   = 9'h000;
        case (state_q)
            MEMWR: begin
                if (ph_q == PH_ISSUE) begin
                    ab_d = {op2_q, op1_q};
                    we_d = 1'b1;
                    do_d = store_data;
                end
            end
            EXEC: begin
                case (ir_q)
                    8'hA9: begin a_d = op1_q; res = op1_q; set_nz = 1'b1; end
                    8'hA2: begin x_d = op1_q; res = op1_q; set_nz = 1'b1; end
                    8'hA0: begin y_d = op1_q; res = op1_q; set_nz = 1'b1; end
                    // For LDA abs the fetched data byte was parked in op1.
                    8'hAD: begin a_d = op1_q; res = op1_q; set_nz = 1'b1; end
                    8'hAA: begin x_d = a_q; res = a_q; set_nz = 1'b1; end
                    8'hA8: begin y_d = a_q; res = a_q; set_nz = 1'b1; end
                    8'h8A: begin a_d = x_q; res = x_q; set_nz = 1'b1; end
                    8'h98: begin a_d = y_q; res = y_q; set_nz = 1'b1; end
                    8'h9A: s_d = x_q;
                    8'hBA: begin x_d = s_q; res = s_q; set_nz = 1'b1; end
                    8'hE8: begin x_d = x_q + 8'd1; res = x_d; set_nz = 1'b1; end
                    8'hC8: begin y_d = y_q + 8'd1; res = y_d; set_nz = 1'b1; end
                    8'hCA: begin x_d = x_q - 8'd1; res = x_d; set_nz = 1'b1; end
                    8'h88: begin y_d = y_q - 8'd1; res = y_d; set_nz = 1'b1; end
                    8'h69: begin
                        sum9   = {1'b0, a_q} + {1'b0, op1_q} + {8'd0, c_q};
                        a_d    = sum9[7:0];
                        c_d    = sum9[8];
                        res    = sum9[7:0];
                        set_nz = 1'b1;
                    end
                    8'h18: c_d = 1'b0;
                    8'h38: c_d = 1'b1;
                    8'h4C: pc_d = {op2_q, op1_q};
                    8'hD0: if (!z_q) pc_d = pc_q + {{8{op1_q[7]}}, op1_q};
                    8'hF0: if (z_q)  pc_d = pc_q + {{8{op1_q[7]}}, op1_q};
                    8'h53: begin
                        for (int i = 0; i < 8; i++) if (op1_q[i]) mpr_d[i] = a_q;
                    end
                    8'h43: begin
                        // Descending scan so the lowest set bit wins.
                        for (int i = 7; i >= 0; i--) if (op1_q[i]) a_d = mpr_q[i];
                    end
                    default: ;
                endcase
            end
            default: begin
                if (ph_q == PH_ISSUE) begin
                    ab_d = rd_addr;
                    re_d = 1'b1;
                end else if (ph_q[1]) begin
                    case (state_q)
                        VEC_LO: op1_d = DI;
                        VEC_HI: pc_d  = {DI, op1_q};
                        FETCH:  begin ir_d  = DI; pc_d = pc_q + 16'd1; end
                        OP1:    begin op1_d = DI; pc_d = pc_q + 16'd1; end
                        OP2:    begin op2_d = DI; pc_d = pc_q + 16'd1; end
                        MEMRD:  op1_d = DI;
                        default: ;
                    endcase
                end
            end
        endcase
        if (set_nz) begin
            n_d = res[7];
            z_d = (res == 8'h00);
        end
    end

    assign AB_21       = {mpr_q[ab_q[15:13]], ab_q[12:0]};
    assign DO          = do_q;
    assign RE          = re_q;
    assign WE          = we_q;
    assign dbg_state_o = state_q;
    assign dbg_ab_o    = ab_q;
    assign dbg_pc_o    = pc_q;
    assign dbg_a_o     = a_q;
    assign dbg_x_o     = x_q;
    assign dbg_y_o     = y_q;
    assign dbg_s_o     = s_q;
    assign dbg_nzc_o   = {n_q, z_q, c_q};

endmodule

// File: tb/tb_huc6280_core_lite.sv
// Bench for huc6280_core_lite: instruction-level model predicts every bus transaction
// and the register file at each opcode fetch; a memory model answers the DUT's reads.
module tb_huc6280_core_lite;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        RDY = 1'b1;
  logic        IRQ = 1'b0;
  logic        NMI = 1'b0;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        RE, WE;
  logic [20:0] AB_21;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_ab, dbg_pc;
  logic [7:0]  dbg_a, dbg_x, dbg_y, dbg_s;
  logic [2:0]  dbg_nzc;

  huc6280_core_lite #(.RESET_VEC(16'hFFFE)) dut (
    .clk(clk), .reset(reset), .AB_21(AB_21), .DI(DI), .DO(DO), .RE(RE), .WE(WE),
    .IRQ(IRQ), .NMI(NMI), .RDY(RDY),
    .dbg_state_o(dbg_state), .dbg_ab_o(dbg_ab), .dbg_pc_o(dbg_pc),
    .dbg_a_o(dbg_a), .dbg_x_o(dbg_x), .dbg_y_o(dbg_y), .dbg_s_o(dbg_s),
    .dbg_nzc_o(dbg_nzc)
  );

  // ---------------- memory seen by the DUT ----------------
  logic [7:0] mem [int];
  logic [7:0] rd_q = 8'h00;
  assign DI = rd_q;

  always @(posedge clk) begin
    if (RE) rd_q <= mem.exists(int'(AB_21)) ? mem[int'(AB_21)] : 8'h00;
    if (WE) mem[int'(AB_21)] = DO;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic active = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic        fetch;
    logic [15:0] ab;
    logic [20:0] ab21;
    logic [7:0]  d;
    logic [7:0]  a, x, y, s;
    logic [2:0]  nzc;
  } txn_t;
  localparam int TW = $bits(txn_t);
  logic [TW-1:0] exp_q[$];

  // ---------------- instruction-level reference model ----------------
  logic [7:0]  mm [int];
  logic [7:0]  m_a, m_x, m_y, m_s;
  logic [7:0]  m_mpr [8];
  logic        m_n, m_z, m_c;
  logic [15:0] m_pc;
  logic [20:0] m_last_wr_ab;
  logic [7:0]  m_last_wr_d;

  function automatic logic [20:0] m_map(input logic [15:0] ab);
    return {m_mpr[ab[15:13]], ab[12:0]};
  endfunction

  task automatic push(input logic wr, input logic fetch, input logic [15:0] ab, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.fetch = fetch; t.ab = ab; t.ab21 = m_map(ab); t.d = d;
    t.a = m_a; t.x = m_x; t.y = m_y; t.s = m_s; t.nzc = {m_n, m_z, m_c};
    exp_q.push_back(t);
  endtask

  task automatic m_read(input logic [15:0] ab, input logic fetch, output logic [7:0] v);
    int p;
    p = int'(m_map(ab));
    v = mm.exists(p) ? mm[p] : 8'h00;
    push(1'b0, fetch, ab, 8'h00);
  endtask

  task automatic m_write(input logic [15:0] ab, input logic [7:0] v);
    push(1'b1, 1'b0, ab, v);
    mm[int'(m_map(ab))] = v;
    m_last_wr_ab = m_map(ab);
    m_last_wr_d  = v;
  endtask

  task automatic m_nz(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  task automatic m_reset();
    logic [7:0] lo, hi;
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_s = 8'hFF;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
    for (int i = 0; i < 8; i++) m_mpr[i] = 8'h00;
    m_read(16'hFFFE, 1'b0, lo);
    m_read(16'hFFFF, 1'b0, hi);
    m_pc = {hi, lo};
  endtask

  task automatic m_step();
    logic [7:0] op, lo, hi, v;
    logic [15:0] ea;
    int sum;
    bit found;
    lo = 8'h00; hi = 8'h00;
    m_read(m_pc, 1'b1, op);
    m_pc = m_pc + 16'd1;
    if (op inside {8'hA9, 8'hA2, 8'hA0, 8'h69, 8'h53, 8'h43, 8'hD0, 8'hF0}) begin
      m_read(m_pc, 1'b0, lo); m_pc = m_pc + 16'd1;
    end else if (op inside {8'hAD, 8'h8D, 8'h8E, 8'h8C, 8'h4C}) begin
      m_read(m_pc, 1'b0, lo); m_pc = m_pc + 16'd1;
      m_read(m_pc, 1'b0, hi); m_pc = m_pc + 16'd1;
    end
    ea = {hi, lo};
    case (op)
      8'hA9: begin m_a = lo; m_nz(m_a); end
      8'hA2: begin m_x = lo; m_nz(m_x); end
      8'hA0: begin m_y = lo; m_nz(m_y); end
      8'hAD: begin m_read(ea, 1'b0, v); m_a = v; m_nz(v); end
      8'h8D: m_write(ea, m_a);
      8'h8E: m_write(ea, m_x);
      8'h8C: m_write(ea, m_y);
      8'hAA: begin m_x = m_a; m_nz(m_x); end
      8'hA8: begin m_y = m_a; m_nz(m_y); end
      8'h8A: begin m_a = m_x; m_nz(m_a); end
      8'h98: begin m_a = m_y; m_nz(m_a); end
      8'h9A: m_s = m_x;
      8'hBA: begin m_x = m_s; m_nz(m_x); end
      8'hE8: begin m_x = 8'(int'(m_x) + 1); m_nz(m_x); end
      8'hC8: begin m_y = 8'(int'(m_y) + 1); m_nz(m_y); end
      8'hCA: begin m_x = 8'(int'(m_x) - 1); m_nz(m_x); end
      8'h88: begin m_y = 8'(int'(m_y) - 1); m_nz(m_y); end
      8'h69: begin
        sum = int'(m_a) + int'(lo) + int'(m_c);
        m_c = (sum > 255);
        m_a = 8'(sum);
        m_nz(m_a);
      end
      8'h18: m_c = 1'b0;
      8'h38: m_c = 1'b1;
      8'h4C: m_pc = ea;
      8'hD0: if (!m_z) m_pc = 16'(int'(m_pc) + int'($signed(lo)));
      8'hF0: if (m_z)  m_pc = 16'(int'(m_pc) + int'($signed(lo)));
      8'h53: for (int i = 0; i < 8; i++) if (lo[i]) m_mpr[i] = m_a;
      8'h43: begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) if (lo[i] && !found) begin m_a = m_mpr[i]; found = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic m_run(input int n);
    for (int i = 0; i < n; i++) m_step();
  endtask

  // Final opcode fetch: pins the register file after the last modelled instruction.
  task automatic m_snapshot();
    push(1'b0, 1'b1, m_pc, 8'h00);
  endtask

  // ---------------- compare process ----------------
  txn_t ct;
  always @(negedge clk) begin
    if (active) begin
      chk("re_we_excl", {31'd0, RE & WE}, 32'd0);
      if ((RE || WE) && exp_q.size() > 0) begin
        if (RDY) begin
          ct = exp_q.pop_front();
          chk("bus_kind", {30'd0, WE, RE}, {30'd0, ct.wr, ~ct.wr});
          chk("ab", dbg_ab, ct.ab);
          chk("ab21", AB_21, ct.ab21);
          if (ct.wr) chk("do", DO, ct.d);
          if (ct.fetch) begin
            chk("reg_a", dbg_a, ct.a);
            chk("reg_x", dbg_x, ct.x);
            chk("reg_y", dbg_y, ct.y);
            chk("reg_s", dbg_s, ct.s);
            chk("flags_nzc", dbg_nzc, ct.nzc);
          end
        end else begin
          ct = exp_q[0];
          chk("stall_ab21", AB_21, ct.ab21);
          chk("stall_kind", {30'd0, WE, RE}, {30'd0, ct.wr, ~ct.wr});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    active = 1'b0;
    reset  = 1'b0;
    RDY    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", dbg_a, 8'h00);
    chk("rst_x", dbg_x, 8'h00);
    chk("rst_y", dbg_y, 8'h00);
    chk("rst_s", dbg_s, 8'hFF);
    chk("rst_nzc", dbg_nzc, 3'b000);
    chk("rst_re_we", {RE, WE}, 2'b00);
    chk("rst_do", DO, 8'h00);
    mem.delete();
    mm.delete();
    exp_q.delete();
  endtask

  task automatic put(input int p, input logic [7:0] v);
    mem[p] = v;
    mm[p]  = v;
  endtask

  // Loads code at a logical address assuming the post-reset mapping (all MPRs zero).
  task automatic put_prog(input logic [15:0] org, input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) put(int'(org[12:0]) + i, b[i]);
    put(13'h1FFE, org[7:0]);
    put(13'h1FFF, org[15:8]);
  endtask

  // mode 0: RDY high, 1: random RDY drops, 2: one 5-cycle stall
  task automatic run_dut(input int budget, input int mode);
    int cyc;
    reset  = 1'b1;
    active = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      case (mode)
        1: begin RDY = ($urandom_range(0, 9) != 0); IRQ = 1'($urandom); NMI = 1'($urandom); end
        2: RDY = !(cyc >= 20 && cyc < 25);
        default: RDY = 1'b1;
      endcase
    end
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    active = 1'b0;
    RDY = 1'b1;
    exp_q.delete();
  endtask

  logic [7:0] rand_ops[$] = '{8'hA9, 8'hA2, 8'hA0, 8'hAD, 8'h8D, 8'h8E, 8'h8C, 8'hAA, 8'hA8,
                              8'h8A, 8'h98, 8'h9A, 8'hBA, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'h69,
                              8'h18, 8'h38, 8'h4C, 8'hD0, 8'hF0, 8'hEA, 8'h53, 8'h43};

  txn_t lt;

  initial begin
    // Load / transfer, run once straight and once with a stall.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      put_prog(16'h8000, '{8'hA9, 8'h42, 8'hAA, 8'hC8, 8'h9A, 8'h4C, 8'hEF, 8'hBE});
      m_reset();
      m_run(5);
      m_snapshot();
      lt = exp_q[0];
      chk("lit_vec_ab21", lt.ab21, 21'h001FFE);
      lt = exp_q[2];
      chk("lit_fetch_ab", lt.ab, 16'h8000);
      chk("lit_fetch_ab21", lt.ab21, 21'h000000);
      chk("lit_ld_a", m_a, 8'h42);
      chk("lit_ld_x", m_x, 8'h42);
      chk("lit_ld_y", m_y, 8'h01);
      chk("lit_ld_s", m_s, 8'h42);
      chk("lit_ld_pc", m_pc, 16'hBEEF);
      run_dut(400, pass == 0 ? 0 : 2);
    end

    // ADC carry/zero.
    do_reset();
    put_prog(16'h8000, '{8'hA9, 8'hFF, 8'h18, 8'h69, 8'h01, 8'h69, 8'h00});
    m_reset();
    m_run(3);
    chk("lit_adc1_a", m_a, 8'h00);
    chk("lit_adc1_nzc", {m_n, m_z, m_c}, 3'b011);
    m_run(1);
    chk("lit_adc2_a", m_a, 8'h01);
    chk("lit_adc2_c", m_c, 1'b0);
    m_snapshot();
    run_dut(400, 0);

    // MMU: TAM, mapped store, TMA, mapped load.
    do_reset();
    put_prog(16'h8000, '{8'hA9, 8'h05, 8'h53, 8'h04, 8'h8D, 8'h34, 8'h45, 8'hA9, 8'h77,
                         8'h43, 8'h04, 8'hA9, 8'h00, 8'hAD, 8'h34, 8'h45});
    m_reset();
    m_run(3);
    chk("lit_mmu_wr_ab21", m_last_wr_ab, 21'h00A534);
    chk("lit_mmu_wr_do", m_last_wr_d, 8'h05);
    chk("lit_mmu_mpr2", m_mpr[2], 8'h05);
    m_run(2);
    chk("lit_tma_a", m_a, 8'h05);
    m_run(2);
    chk("lit_lda_abs_a", m_a, 8'h05);
    m_snapshot();
    run_dut(600, 1);

    // DEX / BNE loop.
    do_reset();
    put_prog(16'h8000, '{8'hA2, 8'h03, 8'hCA, 8'hD0, 8'hFD, 8'h4C, 8'hEF, 8'hBE});
    m_reset();
    m_run(8);
    chk("lit_loop_x", m_x, 8'h00);
    chk("lit_loop_pc", m_pc, 16'hBEEF);
    m_snapshot();
    run_dut(600, 0);

    // Random programs with random RDY stalls.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      for (int p = 0; p < 8192; p++)
        put(p, ($urandom_range(0, 1) != 0) ? rand_ops[$urandom_range(0, rand_ops.size() - 1)]
                                           : 8'($urandom));
      m_reset();
      m_run(150);
      m_snapshot();
      run_dut(5000, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
